// File: rtl/serial_rx_pkg.sv
// Shared helpers for the serial word receiver: one-hot column decode.
package serial_rx_pkg;

  localparam int ONEHOT_MAX = 256;

  // Code 0 decodes to all zeros; code k sets bit k-1. Callers truncate to 2**W-1 bits.
  function automatic logic [ONEHOT_MAX-1:0] onehot_decode(input logic [7:0] code);
    logic [ONEHOT_MAX-1:0] result;
    result = '0;
    if (code != 8'd0) result[code - 8'd1] = 1'b1;
    return result;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for the async serial clock/data plus an armed rising-edge detector.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic clk_in,
  input  logic bit_in,
  output logic sample,
  output logic sample_bit
);

  logic       clk_s1;
  logic       clk_s2;
  logic       bit_s1;
  logic       bit_s2;
  logic       prev_clk;
  logic       armed;
  logic [1:0] fill;

  // fill marks when clk_s2 holds a real input value rather than its reset zero, so a
  // clk_in held high across reset release is never mistaken for a low phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1   <= 1'b0;
      clk_s2   <= 1'b0;
      bit_s1   <= 1'b0;
      bit_s2   <= 1'b0;
      prev_clk <= 1'b0;
      armed    <= 1'b0;
      fill     <= 2'b00;
    end else begin
      clk_s1   <= clk_in;
      clk_s2   <= clk_s1;
      bit_s1   <= bit_in;
      bit_s2   <= bit_s1;
      prev_clk <= clk_s2;
      fill     <= {fill[0], 1'b1};
      if (fill[1] && !clk_s2) armed <= 1'b1;
    end
  end

  assign sample     = armed & clk_s2 & ~prev_clk;
  assign sample_bit = bit_s2;

endmodule

// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver with idle timeout and one-hot column select output.
module serial_word_rx
  import serial_rx_pkg::*;
#(
  parameter int WORD_W      = 3,
  parameter int LSB_FIRST   = 1,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_in,
  input  logic                    bit_in,
  output logic [WORD_W-1:0]       word_data,
  output logic                    word_valid,
  output logic [(2**WORD_W)-2:0]  column_select,
  output logic                    frame_err,
  output logic                    busy
);

  localparam int COL_W  = (2**WORD_W) - 1;
  localparam int CNT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int IDLE_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WORD_W - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  logic              sample;
  logic              sample_bit;
  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] shreg;
  logic [IDLE_W-1:0] idle;
  logic [CNT_W-1:0]  pos;
  logic [WORD_W-1:0] assembled;
  logic              timeout_hit;

  sync_edge_det u_sync (
    .clk        (clk),
    .reset      (reset),
    .clk_in     (clk_in),
    .bit_in     (bit_in),
    .sample     (sample),
    .sample_bit (sample_bit)
  );

  always_comb begin
    assembled = shreg;
    if (LSB_FIRST != 0) pos = cnt;
    else                pos = CNT_LAST - cnt;
    assembled[pos] = sample_bit;
  end

  // A sample edge landing on the timeout cycle keeps the partial word alive.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt != '0) && (idle == IDLE_LAST) && !sample;

  // word_valid is a push-only strobe with no ready: the consumer must take word_data and
  // column_select in the single cycle word_valid is high; word_data then holds until the next word.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      shreg         <= '0;
      idle          <= '0;
      word_data     <= '0;
      word_valid    <= 1'b0;
      column_select <= '0;
      frame_err     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      word_valid    <= 1'b0;
      column_select <= '0;
      frame_err     <= 1'b0;
      if (sample) begin
        idle <= '0;
        if (cnt == CNT_LAST) begin
          cnt           <= '0;
          shreg         <= '0;
          word_data     <= assembled;
          word_valid    <= 1'b1;
          column_select <= COL_W'(onehot_decode(8'(assembled)));
          busy          <= 1'b0;
        end else begin
          cnt   <= cnt + 1'b1;
          shreg <= assembled;
          busy  <= 1'b1;
        end
      end else if (timeout_hit) begin
        cnt       <= '0;
        shreg     <= '0;
        idle      <= '0;
        frame_err <= 1'b1;
        busy      <= 1'b0;
      end else if (cnt == '0 || TIMEOUT_CYC == 0) begin
        idle <= '0;
      end else begin
        idle <= idle + 1'b1;
      end
    end
  end

endmodule
